baccarat_datapath: RTL

Card-holding and scoring datapath for the baccarat table; it answers the dealing state machine's per-card load strobes and returns the hand scores and player third card that the state machine's next-state logic consumes. It latches dealt cards into six 4-bit registers and computes both hand scores modulo 10. It also keeps saturating player/dealer/tie tallies from the win lights and flags protocol errors. It sits between the card source and the state machine, clocked by slow_clock.

---
 rtl/baccarat_if.sv | 40 ++++
 rtl/baccarat_datapath.sv | 115 +++++++++++
 2 files changed

// File: rtl/baccarat_if.sv
// ============================================================================
// Module      : baccarat_if
// Description : Load strobes, result lights, cards, scores, tallies and flags
//               exchanged between the dealing controller and the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface baccarat_if #(
    parameter int TALLY_W = 8
);
    logic [3:0]         new_card;
    logic               load_pcard1, load_pcard2, load_pcard3;
    logic               load_dcard1, load_dcard2, load_dcard3;
    logic               new_hand;
    logic               player_win_light, dealer_win_light;
    logic [3:0]         pcard1, pcard2, pcard3;
    logic [3:0]         dcard1, dcard2, dcard3;
    logic [3:0]         pscore, dscore;
    logic [TALLY_W-1:0] player_tally, dealer_tally, tie_tally;
    logic               bad_card, multi_load;

    modport master (
        output new_card, load_pcard1, load_pcard2, load_pcard3,
               load_dcard1, load_dcard2, load_dcard3, new_hand,
               player_win_light, dealer_win_light,
        input  pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, pscore, dscore,
               player_tally, dealer_tally, tie_tally, bad_card, multi_load
    );

    modport slave (
        input  new_card, load_pcard1, load_pcard2, load_pcard3,
               load_dcard1, load_dcard2, load_dcard3, new_hand,
               player_win_light, dealer_win_light,
        output pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, pscore, dscore,
               player_tally, dealer_tally, tie_tally, bad_card, multi_load
    );
endinterface

`default_nettype wire

// File: rtl/baccarat_datapath.sv
// ============================================================================
// Module      : baccarat_datapath
// Description : Holds dealt cards, scores both hands mod 10, keeps saturating
//               win tallies and sticky protocol-error flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module baccarat_datapath #(
    parameter int TALLY_W = 8
) (
    input  wire logic   slow_clock,
    input  wire logic   resetb,
    baccarat_if.slave   bus
);

    localparam logic [TALLY_W-1:0] c_TALLY_MAX = {TALLY_W{1'b1}};
    localparam logic [TALLY_W-1:0] c_TALLY_ONE = {{(TALLY_W-1){1'b0}}, 1'b1};

    // Index order: player cards 1-3, then dealer cards 1-3
    logic [3:0]         r_card [6];
    logic               r_bad_card;
    logic               r_multi_load;
    logic               r_prev_lit;
    logic [TALLY_W-1:0] r_player_tally, r_dealer_tally, r_tie_tally;

    logic [5:0]         w_load;
    logic               w_valid;
    logic [3:0]         w_card_in;
    logic               w_multi;
    logic               w_lit;
    logic               w_rise;

    function automatic logic [4:0] f_val(input logic [3:0] card);
        return (card != 4'd0 && card <= 4'd9) ? {1'b0, card} : 5'd0;
    endfunction

    function automatic logic [3:0] f_score(input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] c);
        logic [4:0] sum;
        sum = f_val(a) + f_val(b) + f_val(c);
        if (sum >= 5'd20)
            sum = sum - 5'd20;
        else if (sum >= 5'd10)
            sum = sum - 5'd10;
        return sum[3:0];
    endfunction

    assign w_load    = {bus.load_dcard3, bus.load_dcard2, bus.load_dcard1,
                        bus.load_pcard3, bus.load_pcard2, bus.load_pcard1};
    assign w_valid   = (bus.new_card != 4'd0) && (bus.new_card <= 4'd13);
    assign w_card_in = w_valid ? bus.new_card : 4'd0;
    // More than one bit set: clearing the lowest set bit leaves something
    assign w_multi   = (w_load & (w_load - 6'd1)) != 6'd0;
    assign w_lit     = bus.player_win_light | bus.dealer_win_light;
    assign w_rise    = w_lit & ~r_prev_lit;

    always_ff @(posedge slow_clock) begin
        if (!resetb || bus.new_hand) begin
            for (int i = 0; i < 6; i++)
                r_card[i] <= 4'd0;
            r_bad_card   <= 1'b0;
            r_multi_load <= 1'b0;
        end else begin
            for (int i = 0; i < 6; i++)
                if (w_load[i])
                    r_card[i] <= w_card_in;
            if (w_load != 6'd0 && !w_valid)
                r_bad_card <= 1'b1;
            if (w_multi)
                r_multi_load <= 1'b1;
        end
    end

    // Tallies and edge history survive new_hand; only reset clears them
    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            r_prev_lit     <= 1'b0;
            r_player_tally <= '0;
            r_dealer_tally <= '0;
            r_tie_tally    <= '0;
        end else begin
            r_prev_lit <= w_lit;
            if (w_rise) begin
                if (bus.player_win_light && bus.dealer_win_light) begin
                    if (r_tie_tally != c_TALLY_MAX)
                        r_tie_tally <= r_tie_tally + c_TALLY_ONE;
                end else if (bus.player_win_light) begin
                    if (r_player_tally != c_TALLY_MAX)
                        r_player_tally <= r_player_tally + c_TALLY_ONE;
                end else begin
                    if (r_dealer_tally != c_TALLY_MAX)
                        r_dealer_tally <= r_dealer_tally + c_TALLY_ONE;
                end
            end
        end
    end

    assign bus.pcard1       = r_card[0];
    assign bus.pcard2       = r_card[1];
    assign bus.pcard3       = r_card[2];
    assign bus.dcard1       = r_card[3];
    assign bus.dcard2       = r_card[4];
    assign bus.dcard3       = r_card[5];
    assign bus.pscore       = f_score(r_card[0], r_card[1], r_card[2]);
    assign bus.dscore       = f_score(r_card[3], r_card[4], r_card[5]);
    assign bus.player_tally = r_player_tally;
    assign bus.dealer_tally = r_dealer_tally;
    assign bus.tie_tally    = r_tie_tally;
    assign bus.bad_card     = r_bad_card;
    assign bus.multi_load   = r_multi_load;

endmodule

`default_nettype wire
